// File: rtl/dds_ctrl_pkg.sv
// Shared types and default widths for the DDS frequency-sweep controller.
// Build macro SWEEP_TRIANGLE_EN adds the STEP_DN state (triangle sweeps).
package dds_ctrl_pkg;

   localparam int DDS_ADDR_W  = 10;
   localparam int DDS_DWELL_W = 16;

`ifdef SWEEP_TRIANGLE_EN
   typedef enum logic [2:0] {
      IDLE, DWELL, STEP, FINISH, STEP_DN
   } sweep_state_t;
`else
   typedef enum logic [1:0] {
      IDLE, DWELL, STEP, FINISH
   } sweep_state_t;
`endif

endpackage

// File: rtl/dds_dwell_cnt.sv
// Loadable per-step dwell down-counter; expire is high while count is zero.
// Ports: clk, rst_n, load, value -> expire.
module dds_dwell_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] value,
   output logic             expire
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= value;
      else if (cnt != '0)
         cnt <= cnt - {{(WIDTH-1){1'b0}}, 1'b1};
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving fword/pword of the DDS core.
// Ports: start/abort control, cfg_* sweep setup, fword/pword/busy/step_tick/done
// outputs. Macro SWEEP_TRIANGLE_EN enables an up/down (triangle) sweep.
module dds_sweep_ctrl
   import dds_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH  = DDS_ADDR_W,
   parameter int DWELL_WIDTH = DDS_DWELL_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ADDR_WIDTH-1:0]  cfg_f_start,
   input  logic [ADDR_WIDTH-1:0]  cfg_f_stop,
   input  logic [ADDR_WIDTH-1:0]  cfg_f_step,
   input  logic [DWELL_WIDTH-1:0] cfg_dwell,
   input  logic [ADDR_WIDTH-1:0]  cfg_pword,
   input  logic                   cfg_loop,
   output logic [ADDR_WIDTH-1:0]  fword,
   output logic [ADDR_WIDTH-1:0]  pword,
   output logic                   busy,
   output logic                   step_tick,
   output logic                   done
);

   sweep_state_t state, nxt, act, sel;

   logic [ADDR_WIDTH-1:0]  f_start_q, f_stop_q, f_step_q, pword_q;
   logic [DWELL_WIDTH-1:0] dwell_q;
   logic                   loop_q;

   logic                  last_q, last_d;
   logic                  ld, reload, busy_d, done_d;
   logic                  expire, deg, up_clamp;
   logic [ADDR_WIDTH-1:0] ld_val;
   logic [ADDR_WIDTH:0]   up_sum;

`ifdef SWEEP_TRIANGLE_EN
   logic                dn_q, dn_d, dn_clamp;
   logic [ADDR_WIDTH:0] dn_diff;

   assign dn_diff  = {1'b0, fword} - {1'b0, f_step_q};
   assign dn_clamp = dn_diff[ADDR_WIDTH] |
                     (dn_diff[ADDR_WIDTH-1:0] < f_start_q);
`endif

   // Extra bit catches wrap-around past the top of the word range.
   assign up_sum   = {1'b0, fword} + {1'b0, f_step_q};
   assign up_clamp = up_sum[ADDR_WIDTH] |
                     (up_sum[ADDR_WIDTH-1:0] > f_stop_q);
   assign deg      = (f_step_q == '0) | (f_start_q >= f_stop_q);

   dds_dwell_cnt #(
      .WIDTH (DWELL_WIDTH)
   ) u_dwell (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (ld),
      .value  (dwell_q),
      .expire (expire)
   );

   // Shadow copy of the configuration, frozen for the whole sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_start_q <= '0;
         f_stop_q  <= '0;
         f_step_q  <= '0;
         dwell_q   <= '0;
         pword_q   <= '0;
         loop_q    <= 1'b0;
      end else if (state == IDLE && start) begin
         f_start_q <= cfg_f_start;
         f_stop_q  <= cfg_f_stop;
         f_step_q  <= cfg_f_step;
         dwell_q   <= cfg_dwell;
         pword_q   <= cfg_pword;
         loop_q    <= cfg_loop;
      end
   end

   // What to do when the current dwell runs out.
   always_comb begin
      sel = STEP;
`ifdef SWEEP_TRIANGLE_EN
      if (dn_q)
         sel = (deg || last_q || fword == f_start_q) ? FINISH : STEP_DN;
      else if (deg)
         sel = FINISH;
      else if (last_q || fword == f_stop_q)
         sel = STEP_DN;
`else
      if (deg || last_q || fword == f_stop_q)
         sel = FINISH;
`endif
   end

   // STEP as a registered state is the one-cycle arm after start;
   // later steps are taken directly on the dwell expiry edge.
   always_comb begin
      nxt    = state;
      act    = IDLE;
      reload = 1'b0;
      ld     = 1'b0;
      ld_val = fword;
      last_d = last_q;
      busy_d = busy;
      done_d = 1'b0;
`ifdef SWEEP_TRIANGLE_EN
      dn_d   = dn_q;
`endif
      unique case (state)
         IDLE:  if (start) nxt = STEP;
         STEP:  begin
            reload = 1'b1;
            busy_d = 1'b1;
            nxt    = DWELL;
         end
         DWELL: if (expire) act = sel;
         default: nxt = IDLE;
      endcase

      if (act == FINISH) begin
         if (!loop_q) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            nxt    = IDLE;
         end
`ifdef SWEEP_TRIANGLE_EN
         else if (!deg)
            act = STEP;
`endif
         else
            reload = 1'b1;
      end

      if (reload) begin
         ld     = 1'b1;
         ld_val = f_start_q;
         last_d = 1'b0;
`ifdef SWEEP_TRIANGLE_EN
         dn_d   = 1'b0;
`endif
      end

      if (act == STEP) begin
         ld     = 1'b1;
         ld_val = up_clamp ? f_stop_q : up_sum[ADDR_WIDTH-1:0];
         last_d = up_clamp;
`ifdef SWEEP_TRIANGLE_EN
         dn_d   = 1'b0;
`endif
      end

`ifdef SWEEP_TRIANGLE_EN
      if (act == STEP_DN) begin
         ld     = 1'b1;
         ld_val = dn_clamp ? f_start_q : dn_diff[ADDR_WIDTH-1:0];
         last_d = dn_clamp;
         dn_d   = 1'b1;
      end
`endif

      if (abort) begin
         nxt    = IDLE;
         ld     = 1'b0;
         busy_d = 1'b0;
         done_d = 1'b0;
         last_d = last_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         fword     <= '0;
         pword     <= '0;
         busy      <= 1'b0;
         step_tick <= 1'b0;
         done      <= 1'b0;
         last_q    <= 1'b0;
`ifdef SWEEP_TRIANGLE_EN
         dn_q      <= 1'b0;
`endif
      end else begin
         state     <= nxt;
         busy      <= busy_d;
         step_tick <= ld;
         done      <= done_d;
         last_q    <= last_d;
`ifdef SWEEP_TRIANGLE_EN
         dn_q      <= dn_d;
`endif
         if (ld)
            fword <= ld_val;
         if (state == STEP && !abort)
            pword <= pword_q;
      end
   end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: sweep-list model plus literal pins.
// Honors SWEEP_TRIANGLE_EN to expect the up/down sweep shape.
module tb_dds_sweep_ctrl;

   localparam int AW = 10;
   localparam int DW = 16;
   localparam int N  = 512;
`ifdef SWEEP_TRIANGLE_EN
   localparam bit TRI = 1'b1;
`else
   localparam bit TRI = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] cfg_f_start = '0;
   logic [AW-1:0] cfg_f_stop = '0;
   logic [AW-1:0] cfg_f_step = '0;
   logic [DW-1:0] cfg_dwell = '0;
   logic [AW-1:0] cfg_pword = '0;
   logic          cfg_loop = 1'b0;
   logic [AW-1:0] fword, pword;
   logic          busy, step_tick, done;

   dds_sweep_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .cfg_f_start (cfg_f_start),
      .cfg_f_stop  (cfg_f_stop),
      .cfg_f_step  (cfg_f_step),
      .cfg_dwell   (cfg_dwell),
      .cfg_pword   (cfg_pword),
      .cfg_loop    (cfg_loop),
      .fword       (fword),
      .pword       (pword),
      .busy        (busy),
      .step_tick   (step_tick),
      .done        (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int tick_cnt = 0;

   // Expected outputs after each rising edge, indexed by edge number.
   int e_fw[N];
   int e_pw[N];
   int e_busy[N];
   int e_tick[N];
   int e_done[N];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Model: list the frequency words the sweep visits, each held dw+1 cycles.
   task automatic plan(input int s, input int fs, input int fe,
                       input int st, input int dw, input int pw,
                       input int lp);
      int seq[$];
      int v, t, idx;
      bit dg;
      dg = (st == 0) || (fs >= fe);
      seq.push_back(fs);
      if (!dg) begin
         v = fs;
         do begin
            v = v + st;
            seq.push_back(v >= fe ? fe : v);
         end while (v < fe);
         if (TRI) begin
            v = fe;
            do begin
               v = v - st;
               seq.push_back(v <= fs ? fs : v);
            end while (v > fs);
         end
      end
      t   = s + 1;
      idx = 0;
      while (t < N) begin
         for (int k = 0; k <= dw && t < N; k++) begin
            e_fw[t]   = seq[idx];
            e_pw[t]   = pw;
            e_busy[t] = 1;
            e_tick[t] = (k == 0) ? 1 : 0;
            e_done[t] = 0;
            t++;
         end
         idx++;
         if (idx == seq.size()) begin
            if (lp != 0) begin
               idx = (TRI && seq.size() > 1) ? 1 : 0;
            end else begin
               for (int u = t; u < N; u++) begin
                  e_fw[u]   = seq[idx-1];
                  e_pw[u]   = pw;
                  e_busy[u] = 0;
                  e_tick[u] = 0;
                  e_done[u] = (u == t) ? 1 : 0;
               end
               t = N;
            end
         end
      end
   endtask

   task automatic plan_abort(input int a);
      for (int u = a; u < N; u++) begin
         e_fw[u]   = e_fw[a-1];
         e_pw[u]   = e_pw[a-1];
         e_busy[u] = 0;
         e_tick[u] = 0;
         e_done[u] = 0;
      end
   endtask

   task automatic plan_reset(input int r);
      for (int u = r; u < N; u++) begin
         e_fw[u]   = 0;
         e_pw[u]   = 0;
         e_busy[u] = 0;
         e_tick[u] = 0;
         e_done[u] = 0;
      end
   endtask

   task automatic go(output int s);
      s = cyc + 1;
      plan(s, int'(cfg_f_start), int'(cfg_f_stop), int'(cfg_f_step),
           int'(cfg_dwell), int'(cfg_pword), int'(cfg_loop));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_to(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic set_cfg(input int fs, input int fe, input int st,
                          input int dw, input int pw, input bit lp);
      cfg_f_start = AW'(fs);
      cfg_f_stop  = AW'(fe);
      cfg_f_step  = AW'(st);
      cfg_dwell   = DW'(dw);
      cfg_pword   = AW'(pw);
      cfg_loop    = lp;
   endtask

   always @(negedge clk) begin
      tick_cnt += int'(step_tick);
      if (cyc < N) begin
         chk("fword", int'(fword), e_fw[cyc]);
         chk("pword", int'(pword), e_pw[cyc]);
         chk("busy", int'(busy), e_busy[cyc]);
         chk("step_tick", int'(step_tick), e_tick[cyc]);
         chk("done", int'(done), e_done[cyc]);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      repeat (3) @(negedge clk);
      chk("rst_fword", int'(fword), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic sawtooth, with cfg changes and a stray start mid-sweep.
      set_cfg(10, 22, 5, 2, 7, 1'b0);
      go(s);
      tick_cnt = 0;
      cfg_f_step = AW'(1);
      cfg_f_stop = AW'(500);
      wait_to(s + 1);
      chk("t1_f10", int'(fword), 10);
      chk("t1_tick", int'(step_tick), 1);
      chk("t1_pword", int'(pword), 7);
      wait_to(s + 4);
      chk("t1_f15", int'(fword), 15);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_to(s + 7);
      chk("t1_f20", int'(fword), 20);
      wait_to(s + 10);
      chk("t1_f22", int'(fword), 22);
`ifndef SWEEP_TRIANGLE_EN
      wait_to(s + 13);
      chk("t1_done", int'(done), 1);
      chk("t1_busy", int'(busy), 0);
      wait_to(s + 15);
      chk("t1_ticks", tick_cnt, 4);
`else
      wait_to(s + 13);
      chk("t6_f17", int'(fword), 17);
      wait_to(s + 19);
      chk("t6_f10", int'(fword), 10);
      wait_to(s + 22);
      chk("t6_done", int'(done), 1);
      wait_to(s + 24);
      chk("t6_ticks", tick_cnt, 7);
`endif
      repeat (2) @(negedge clk);

      // Looped sweep, then abort.
      set_cfg(10, 22, 5, 2, 7, 1'b1);
      go(s);
      wait_to(s + 13);
`ifndef SWEEP_TRIANGLE_EN
      chk("t2_reload", int'(fword), 10);
      chk("t2_tick", int'(step_tick), 1);
`endif
      chk("t2_nodone", int'(done), 0);
      wait_to(s + 17);
      abort = 1'b1;
      plan_abort(s + 18);
      @(negedge clk);
      abort = 1'b0;
      chk("t2_abort_busy", int'(busy), 0);
      chk("t2_abort_f", int'(fword), TRI ? 12 : 15);
      repeat (3) @(negedge clk);

      // Carry clamp at the top of the word range.
      set_cfg(1020, 1023, 8, 0, 3, 1'b0);
      go(s);
      wait_to(s + 1);
      chk("t3_f1020", int'(fword), 1020);
      wait_to(s + 2);
      chk("t3_f1023", int'(fword), 1023);
      wait_to(s + 3);
      chk("t3_end", TRI ? int'(fword) : int'(done), TRI ? 1020 : 1);
      repeat (3) @(negedge clk);

      // Zero step: single dwell at f_start.
      set_cfg(100, 200, 0, 3, 0, 1'b0);
      go(s);
      wait_to(s + 4);
      chk("t4_hold", int'(fword), 100);
      chk("t4_busy", int'(busy), 1);
      wait_to(s + 5);
      chk("t4_done", int'(done), 1);
      wait_to(s + 8);
      chk("t4_keep", int'(fword), 100);
      chk("t4_idle", int'(busy), 0);

      // start and abort together from IDLE.
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_conflict", int'(busy), 0);

      // Asynchronous reset in the middle of a sweep.
      set_cfg(10, 22, 5, 2, 7, 1'b0);
      go(s);
      wait_to(s + 5);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_f", int'(fword), 0);
      chk("t5_rst_busy", int'(busy), 0);
      plan_reset(cyc);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("t5_after", int'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
